rgb_pwm_driver: RTL and testbench

//  Drives a physical common-cathode RGB LED from the 24-bit light word produced by the

---
 rtl/rgb_pwm_driver.sv | 127 ++++++++++++
 tb/tb_rgb_pwm_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_driver.sv
// PWM driver for a common-cathode RGB LED: three 8-bit channels with optional linear fade.
// Displayed levels only change at PWM period boundaries so no pulse is ever cut short.
module rgb_pwm_driver #(
    parameter int PRESCALE     = 4,
    parameter int STEP_PERIODS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] light,
    input  logic        load,
    input  logic        fade,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        busy,
    output logic        done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] STEP_MAX  = SW'(STEP_PERIODS - 1);

    typedef enum logic {IDLE, FADING} state_t;

    state_t        state_reg, state_next;
    logic          done_reg, done_next;
    logic [PW-1:0] presc_reg;
    logic [7:0]    pwm_cnt_reg;
    logic [SW-1:0] per_cnt_reg;
    logic          tick, boundary, step_now;
    logic [2:0]    led_vec, ne_now, eq_next;

    assign tick     = (presc_reg == PRESC_MAX);
    assign boundary = tick && (pwm_cnt_reg == 8'hFF);
    assign step_now = (per_cnt_reg == STEP_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_reg   <= '0;
            pwm_cnt_reg <= '0;
            per_cnt_reg <= '0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + PW'(1);
            if (tick)
                pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
            // Period counter runs regardless of fade/load so the step cadence never restarts.
            if (boundary)
                per_cnt_reg <= step_now ? '0 : per_cnt_reg + SW'(1);
        end
    end

    // Channel 0 = blue, 1 = green, 2 = red, matching the {R,G,B} packing of light.
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic [7:0] target_reg, target_next;
        logic [7:0] level_reg, level_next;
        logic       led_reg;

        assign target_next = load ? light[gi*8 +: 8] : target_reg;

        always_comb begin
            level_next = level_reg;
            if (boundary) begin
                if (!fade)
                    level_next = target_reg;
                else if (step_now) begin
                    if (level_reg < target_reg)
                        level_next = level_reg + 8'd1;
                    else if (level_reg > target_reg)
                        level_next = level_reg - 8'd1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                target_reg <= '0;
                level_reg  <= '0;
                led_reg    <= 1'b0;
            end else begin
                target_reg <= target_next;
                level_reg  <= level_next;
                led_reg    <= (pwm_cnt_reg < level_reg);
            end
        end

        assign led_vec[gi] = led_reg;
        assign ne_now[gi]  = (level_reg != target_reg);
        assign eq_next[gi] = (level_next == target_next);
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|ne_now)
                    state_next = FADING;
            end
            FADING: begin
                // A coincident load is folded into eq_next, so it can veto completion.
                if (boundary && (&eq_next)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    assign led_r = led_vec[2];
    assign led_g = led_vec[1];
    assign led_b = led_vec[0];
    assign busy  = (state_reg == FADING);
    assign done  = done_reg;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: jump table, fade up/down, async reset, slow step.
module tb_rgb_pwm_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] light = 24'h0;
    logic        load = 1'b0;
    logic        fade = 1'b0;

    logic m_r, m_g, m_b, m_busy, m_done;
    logic p_r, p_g, p_b, p_busy, p_done;
    logic s_r, s_g, s_b, s_busy, s_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int main_done_cnt = 0;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.PRESCALE(1), .STEP_PERIODS(1)) u_main (
        .clk(clk), .rst(rst), .light(light), .load(load), .fade(fade),
        .led_r(m_r), .led_g(m_g), .led_b(m_b), .busy(m_busy), .done(m_done));

    rgb_pwm_driver #(.PRESCALE(4), .STEP_PERIODS(1)) u_p4 (
        .clk(clk), .rst(rst), .light(light), .load(load), .fade(fade),
        .led_r(p_r), .led_g(p_g), .led_b(p_b), .busy(p_busy), .done(p_done));

    rgb_pwm_driver #(.PRESCALE(1), .STEP_PERIODS(3)) u_s3 (
        .clk(clk), .rst(rst), .light(light), .load(load), .fade(fade),
        .led_r(s_r), .led_g(s_g), .led_b(s_b), .busy(s_busy), .done(s_done));

    // Reference edge count since reset release; with PRESCALE=1 it equals pwm_cnt mod 256.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (m_done) main_done_cnt <= main_done_cnt + 1;
    end

    typedef struct {
        logic [23:0] light;
        int          er;
        int          eg;
        int          eb;
        bit          edone;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pulse_load(input logic [23:0] v);
        light = v;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_bnd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((cyc % 256) != 0 && n < 600);
        if (n >= 600) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_bnd: got timeout after %0d cycles, expected a period boundary", n);
        end
    endtask

    // Counts high samples on the main instance over one PWM period.
    task automatic measure(output int r, output int g, output int b,
                           output int busy_low, output int dn);
        r = 0; g = 0; b = 0; busy_low = 0; dn = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            r += int'(m_r);
            g += int'(m_g);
            b += int'(m_b);
            if (i < 255) begin
                busy_low += int'(!m_busy);
                dn       += int'(m_done);
            end
        end
    endtask

    initial begin
        int r, g, b, bl, dn, hi, d0, bad, n;

        vecs[0] = '{24'h8000FF, 128,   0, 255, 1'b1};
        vecs[1] = '{24'h01FE00,   1, 254,   0, 1'b1};
        vecs[2] = '{24'hFF7F10, 255, 127,  16, 1'b1};
        vecs[3] = '{24'hFF7F10, 255, 127,  16, 1'b0};
        vecs[4] = '{24'h000000,   0,   0,   0, 1'b1};

        // 1. Reset held with a load pending
        light = 24'hFFFFFF;
        load  = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_leds", int'({m_r, m_g, m_b, p_r, p_g, p_b, s_r, s_g, s_b}), 0);
        check("rst_busy", int'({m_busy, p_busy, s_busy}), 0);
        check("rst_done", int'({m_done, p_done, s_done}), 0);
        load = 1'b0;
        rst  = 1'b1;
        hi = 0;
        repeat (600) begin
            @(negedge clk);
            hi += int'(m_r | m_g | m_b | p_r | p_g | p_b | s_r | s_g | s_b | m_busy);
        end
        check("post_rst_idle", hi, 0);

        // 2. Jump mode table
        do_reset();
        fade = 1'b0;
        foreach (vecs[k]) begin
            pulse_load(vecs[k].light);
            @(negedge clk);
            check($sformatf("jump%0d_busy_rise", k), int'(m_busy), int'(vecs[k].edone));
            wait_bnd();
            check($sformatf("jump%0d_done", k), int'(m_done), int'(vecs[k].edone));
            check($sformatf("jump%0d_busy_drop", k), int'(m_busy), 0);
            measure(r, g, b, bl, dn);
            check($sformatf("jump%0d_r", k), r, vecs[k].er);
            check($sformatf("jump%0d_g", k), g, vecs[k].eg);
            check($sformatf("jump%0d_b", k), b, vecs[k].eb);
            check($sformatf("jump%0d_extra_done", k), dn, 0);
        end

        // 3. Fade up 0 -> 3
        do_reset();
        fade = 1'b1;
        pulse_load(24'h000000);
        pulse_load(24'h000003);
        wait_bnd();
        check("fup_done_early", int'(m_done), 0);
        check("fup_busy", int'(m_busy), 1);
        measure(r, g, b, bl, dn);
        check("fup_b1", b, 1);
        check("fup_busy1", bl, 0);
        measure(r, g, b, bl, dn);
        check("fup_b2", b, 2);
        check("fup_done", int'(m_done), 1);
        check("fup_busy_drop", int'(m_busy), 0);
        measure(r, g, b, bl, dn);
        check("fup_b3", b, 3);
        check("fup_extra_done", dn, 0);

        // 4. Retarget mid-fade: up to 10, then down to 4
        do_reset();
        @(negedge clk);
        d0 = main_done_cnt;
        fade = 1'b1;
        pulse_load(24'h0000FF);
        repeat (9) wait_bnd();
        measure(r, g, b, bl, dn);
        check("retgt_b9", b, 9);
        pulse_load(24'h000004);
        bad = 0;
        repeat (5) begin
            wait_bnd();
            bad += int'(!m_busy) + int'(m_done);
        end
        check("retgt_busy_held", bad, 0);
        measure(r, g, b, bl, dn);
        check("retgt_b5", b, 5);
        check("retgt_busy_low", bl, 0);
        check("retgt_done", int'(m_done), 1);
        repeat (2) @(negedge clk);
        check("retgt_done_once", main_done_cnt - d0, 1);
        measure(r, g, b, bl, dn);
        check("retgt_b4", b, 4);

        // 5. Async reset mid-fade on the PRESCALE=4 instance
        do_reset();
        fade = 1'b1;
        pulse_load(24'h0000FF);
        n = 0;
        while (!(cyc > 3100 && p_b) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("arst_found_high", int'(p_b), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_p4_leds", int'({p_r, p_g, p_b}), 0);
        check("arst_p4_busy", int'(p_busy), 0);
        check("arst_main_leds", int'({m_r, m_g, m_b}), 0);
        @(negedge clk);
        rst = 1'b1;
        hi = 0;
        repeat (1100) begin
            @(negedge clk);
            hi += int'(p_b) + int'(p_busy);
        end
        check("arst_levels_zero", hi, 0);

        // 6. Slow step: STEP_PERIODS=3 instance
        do_reset();
        fade = 1'b1;
        pulse_load(24'h010000);
        hi = 0;
        n = 0;
        while (cyc != 768 && n < 1000) begin
            @(negedge clk);
            hi += int'(s_r);
            n++;
        end
        check("slow_reached_bnd3", cyc, 768);
        check("slow_r_before", hi, 0);
        check("slow_done", int'(s_done), 1);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(s_r);
        end
        check("slow_r_after", hi, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
